// File: rtl/wb_xbar_rr.sv
// wb_xbar_rr: round-robin Wishbone shared-bus interconnect with adr[31:28] slave decode and decode-miss error.
// Define WB_XBAR_TIMEOUT_EN to add the per-transfer ack timeout.
module wb_xbar_rr #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 5,
    parameter int TIMEOUT     = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [NUM_MASTERS-1:0]    m_cyc_i,
    input  logic [NUM_MASTERS-1:0]    m_stb_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [32*NUM_MASTERS-1:0] m_adr_i,
    input  logic [32*NUM_MASTERS-1:0] m_dat_i,
    input  logic [4*NUM_MASTERS-1:0]  m_sel_i,
    output logic [32*NUM_MASTERS-1:0] m_dat_o,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [NUM_MASTERS-1:0]    m_err_o,
    output logic [NUM_SLAVES-1:0]     s_cyc_o,
    output logic [NUM_SLAVES-1:0]     s_stb_o,
    output logic                      s_we_o,
    output logic [31:0]               s_adr_o,
    output logic [31:0]               s_dat_o,
    output logic [3:0]                s_sel_o,
    input  logic [32*NUM_SLAVES-1:0]  s_dat_i,
    input  logic [NUM_SLAVES-1:0]     s_ack_i,
    input  logic [NUM_SLAVES-1:0]     s_err_i
);
    localparam int MW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [MW-1:0] owner, last, win;
    logic          busy, hit, o_cyc, o_stb, sel_ack, sel_err, miss_err, tmo, err;
    logic [31:0]   o_adr, sel_dat;
    logic [3:0]    idx;

    assign busy = state == BUSY;
    assign idx  = o_adr[31:28];
    assign hit  = busy && ({1'b0, idx} < 5'(NUM_SLAVES));
    assign err  = sel_err | miss_err | (tmo & ~sel_ack);

    // Lowest requester above last wins; otherwise wrap to the lowest at or below last.
    always_comb begin
        win = last;
        for (int j = NUM_MASTERS - 1; j >= 0; j--)
            if (m_cyc_i[j] && MW'(j) <= last) win = MW'(j);
        for (int j = NUM_MASTERS - 1; j >= 0; j--)
            if (m_cyc_i[j] && MW'(j) > last) win = MW'(j);
    end

    always_comb begin
        o_cyc   = 1'b0;
        o_stb   = 1'b0;
        s_we_o  = 1'b0;
        o_adr   = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (busy && owner == MW'(i)) begin
                o_cyc   = m_cyc_i[i];
                o_stb   = m_stb_i[i];
                s_we_o  = m_we_i[i];
                o_adr   = m_adr_i[32*i +: 32];
                s_dat_o = m_dat_i[32*i +: 32];
                s_sel_o = m_sel_i[4*i +: 4];
            end
    end

    assign s_adr_o = o_adr;

    always_comb begin
        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_dat = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            s_cyc_o[k] = hit && idx == 4'(k);
            s_stb_o[k] = s_cyc_o[k] && o_stb && !tmo;
            sel_ack    = sel_ack | (s_cyc_o[k] & s_ack_i[k]);
            sel_err    = sel_err | (s_cyc_o[k] & s_err_i[k]);
            sel_dat    = sel_dat | ({32{s_cyc_o[k]}} & s_dat_i[32*k +: 32]);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_ack_o[i]         = busy && owner == MW'(i) && sel_ack;
            m_err_o[i]         = busy && owner == MW'(i) && err;
            m_dat_o[32*i +: 32] = (busy && owner == MW'(i)) ? sel_dat : 32'h0;
        end
    end

`ifdef WB_XBAR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Fires on the TIMEOUT-th waiting cycle; independent of ack so the stb gate has no loop.
    assign tmo = hit && o_stb && cnt == CW'(TIMEOUT - 1);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            cnt <= '0;
        else
            cnt <= (hit && o_stb && !sel_ack && !sel_err && !tmo) ? cnt + CW'(1) : '0;
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            owner    <= '0;
            last     <= MW'(NUM_MASTERS - 1);
            miss_err <= 1'b0;
        end else begin
            miss_err <= busy && o_stb && !hit && !miss_err;
            if (state == IDLE && |m_cyc_i) begin
                state <= BUSY;
                owner <= win;
                last  <= win;
            end else if (busy && !o_cyc) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_wb_xbar_rr.sv
// tb_wb_xbar_rr: directed self-checking bench for wb_xbar_rr (2 masters, 5 slaves, TIMEOUT=4).
// Timeout scenarios follow WB_XBAR_TIMEOUT_EN the same way the RTL does.
module tb_wb_xbar_rr;
    logic         clk, rst;
    logic [1:0]   m_cyc, m_stb, m_we, m_ack, m_err;
    logic [63:0]  m_adr, m_dat, m_dat_o;
    logic [7:0]   m_sel;
    logic [4:0]   s_cyc, s_stb, s_ack, s_err, ack_mask, ack_force;
    logic         s_we;
    logic [31:0]  s_adr, s_dat_o;
    logic [3:0]   s_sel;
    logic [159:0] s_dat_i;
    int           pass = 0;
    int           total = 0;

    // Slave model: acks combinationally to its strobe when enabled, or forced directly.
    assign s_ack = (s_stb & ack_mask) | ack_force;

    wb_xbar_rr #(.NUM_MASTERS(2), .NUM_SLAVES(5), .TIMEOUT(4)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr),
        .m_dat_i(m_dat), .m_sel_i(m_sel), .m_dat_o(m_dat_o), .m_ack_o(m_ack),
        .m_err_o(m_err), .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_sel_o(s_sel), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack), .s_err_i(s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all;
        m_cyc = 0; m_stb = 0; m_we = 0; m_adr = 0; m_dat = 0; m_sel = 0;
        ack_mask = 0; ack_force = 0;
    endtask

    task automatic test_reset;
        rst = 1; idle_all();
        tick(); tick();
        total++;
        if ({s_cyc, s_stb, m_ack, m_err} !== 14'h0) $display("FAIL reset_idle got %h exp 0", {s_cyc, s_stb, m_ack, m_err});
        else pass++;
        rst = 0;
        m_cyc = 2'b01; m_stb = 2'b01; m_adr = {32'h1000_0010, 32'h1000_0000}; ack_mask = 5'b00010;
        tick();
        total++;
        if ({s_stb, m_ack} !== {5'b00010, 2'b01}) $display("FAIL grant_m0 got %b exp %b", {s_stb, m_ack}, {5'b00010, 2'b01});
        else pass++;
        #2 rst = 1;
        #1;
        total++;
        if ({s_cyc, s_stb, m_ack, m_err} !== 14'h0) $display("FAIL reset_mid got %h exp 0", {s_cyc, s_stb, m_ack, m_err});
        else pass++;
        m_cyc = 2'b11; m_stb = 2'b11;
        tick();
        rst = 0;
        tick();
        total++;
        if (m_ack !== 2'b01 || s_adr !== 32'h1000_0000) $display("FAIL reset_tie got ack %b adr %h exp 01 10000000", m_ack, s_adr);
        else pass++;
        idle_all(); tick(); tick();
    endtask

    task automatic test_round_robin;
        logic [1:0]  ea;
        logic [63:0] ed;
        rst = 1; #1; rst = 0;
        m_adr = {32'h1000_0000, 32'h1000_0000}; m_cyc = 2'b11; m_stb = 2'b11; ack_mask = 5'b00010;
        tick();
        for (int g = 0; g < 4; g++) begin
            ea = (g % 2 == 0) ? 2'b01 : 2'b10;
            ed = (g % 2 == 0) ? {32'h0, 32'h1234_5678} : {32'h1234_5678, 32'h0};
            total++;
            if (m_ack !== ea) $display("FAIL rr_grant%0d got %b exp %b", g, m_ack, ea);
            else pass++;
            total++;
            if (m_dat_o !== ed) $display("FAIL rr_data%0d got %h exp %h", g, m_dat_o, ed);
            else pass++;
            m_cyc[g % 2] = 0; m_stb[g % 2] = 0;
            tick();
            total++;
            if (s_cyc !== 5'b0 || m_ack !== 2'b0) $display("FAIL rr_dead%0d got cyc %b ack %b exp 0 0", g, s_cyc, m_ack);
            else pass++;
            m_cyc[g % 2] = 1; m_stb[g % 2] = 1;
            tick();
        end
        idle_all(); tick(); tick();
    endtask

    task automatic test_decode;
        m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10; m_adr = {32'h4000_0004, 32'h0};
        m_dat = {32'h20, 32'h0}; m_sel = {4'b0001, 4'b0000}; ack_mask = 5'b10000;
        #1;
        total++;
        if (s_cyc !== 5'b0) $display("FAIL dec_latency got %b exp 00000", s_cyc);
        else pass++;
        tick();
        total++;
        if ({s_cyc, s_stb} !== 10'b10000_10000) $display("FAIL dec_sel got %b exp 1000010000", {s_cyc, s_stb});
        else pass++;
        total++;
        if ({s_adr, s_dat_o} !== {32'h4000_0004, 32'h20}) $display("FAIL dec_bus got %h exp 4000000400000020", {s_adr, s_dat_o});
        else pass++;
        total++;
        if ({s_we, s_sel} !== 5'b10001) $display("FAIL dec_we_sel got %b exp 10001", {s_we, s_sel});
        else pass++;
        total++;
        if ({m_ack, m_err} !== 4'b1000) $display("FAIL dec_ack got %b exp 1000", {m_ack, m_err});
        else pass++;
        total++;
        if (m_dat_o !== {32'hDEAD_0004, 32'h0}) $display("FAIL dec_rdata got %h exp dead000400000000", m_dat_o);
        else pass++;
        idle_all(); tick(); tick();
    endtask

    task automatic test_decode_miss;
        m_cyc = 2'b01; m_stb = 2'b01; m_adr = {32'h0, 32'h7000_0000}; ack_mask = 5'b11111;
        tick();
        total++;
        if ({s_cyc, s_stb, m_ack, m_err} !== 14'h0) $display("FAIL miss_c1 got %h exp 0", {s_cyc, s_stb, m_ack, m_err});
        else pass++;
        tick();
        total++;
        if (m_err !== 2'b01) $display("FAIL miss_err got %b exp 01", m_err);
        else pass++;
        m_stb = 2'b00;
        tick();
        total++;
        if (m_err !== 2'b00) $display("FAIL miss_once got %b exp 00", m_err);
        else pass++;
        m_stb = 2'b01;
        tick();
        total++;
        if (m_err !== 2'b01) $display("FAIL miss_rep1 got %b exp 01", m_err);
        else pass++;
        tick();
        total++;
        if (m_err !== 2'b00) $display("FAIL miss_gap got %b exp 00", m_err);
        else pass++;
        tick();
        total++;
        if (m_err !== 2'b01) $display("FAIL miss_rep2 got %b exp 01", m_err);
        else pass++;
        idle_all(); tick(); tick();
    endtask

`ifdef WB_XBAR_TIMEOUT_EN
    task automatic test_timeout;
        m_cyc = 2'b01; m_stb = 2'b01; m_adr = {32'h0, 32'h2000_0000};
        tick();
        for (int w = 1; w <= 3; w++) begin
            total++;
            if (m_err !== 2'b00 || s_stb !== 5'b00100) $display("FAIL tmo_wait%0d got err %b stb %b exp 00 00100", w, m_err, s_stb);
            else pass++;
            tick();
        end
        total++;
        if (m_err !== 2'b01 || s_stb !== 5'b0) $display("FAIL tmo_err got err %b stb %b exp 01 00000", m_err, s_stb);
        else pass++;
        tick();
        total++;
        if (m_err !== 2'b00 || s_stb !== 5'b00100) $display("FAIL tmo_clear got err %b stb %b exp 00 00100", m_err, s_stb);
        else pass++;
        idle_all(); tick(); tick();
        m_cyc = 2'b01; m_stb = 2'b01; m_adr = {32'h0, 32'h2000_0000};
        tick(); tick(); tick(); tick();
        ack_force = 5'b00100;
        #1;
        total++;
        if ({m_ack, m_err} !== 4'b0100) $display("FAIL tmo_ack_wins got %b exp 0100", {m_ack, m_err});
        else pass++;
        idle_all(); tick(); tick();
    endtask
`else
    task automatic test_timeout;
        int errs;
        errs = 0;
        m_cyc = 2'b01; m_stb = 2'b01; m_adr = {32'h0, 32'h2000_0000};
        tick();
        repeat (100) begin
            if (m_err !== 2'b00 || s_stb !== 5'b00100) errs++;
            tick();
        end
        total++;
        if (errs !== 0) $display("FAIL no_timeout got %0d bad cycles exp 0", errs);
        else pass++;
        idle_all(); tick(); tick();
    endtask
`endif

    initial begin
        s_err = 0;
        s_dat_i = {32'hDEAD_0004, 32'hDEAD_0003, 32'hDEAD_0002, 32'h1234_5678, 32'hDEAD_0000};
        test_reset();
        test_round_robin();
        test_decode();
        test_decode_miss();
        test_timeout();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/wb_xbar_rr.md
# wb_xbar_rr

Parametrised Wishbone shared-bus interconnect: successor to the fixed 8-master/16-slave `wb_conmax_top` instance in `openmips_min_sopc`. It connects NUM_MASTERS masters (CPU instruction and data ports, and later DMA) to NUM_SLAVES slaves (ROM, UART, GPIO, PLIC, CLINT, ...). Features:
- Round-robin arbitration with bus lock for the whole `cyc` cycle.
- Address decode on adr[31:28].
- Decode-miss error response.
- Optional per-transfer ack timeout.

## Interface
Parameters:
- NUM_MASTERS, 2, number of masters, 1..8
- NUM_SLAVES, 5, number of slaves, 1..16; slave k owns adr[31:28]==k
- TIMEOUT, 255, cycles a strobed transfer may wait for ack/err before forced error (1..65535)

Ports:
- wb_clk_i  in  1  single clock, all logic on rising edge
- wb_rst_i  in  1  asynchronous, active-high reset
- m_cyc_i  in  NUM_MASTERS  per-master cycle
- m_stb_i  in  NUM_MASTERS  per-master strobe
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_adr_i  in  32*NUM_MASTERS  master i at bits [32i+31:32i]
- m_dat_i  in  32*NUM_MASTERS  write data, same packing
- m_sel_i  in  4*NUM_MASTERS  byte selects, master i at [4i+3:4i]
- m_dat_o  out  32*NUM_MASTERS  read data
- m_ack_o  out  NUM_MASTERS  acknowledge
- m_err_o  out  NUM_MASTERS  error
- s_cyc_o  out  NUM_SLAVES  per-slave cycle
- s_stb_o  out  NUM_SLAVES  per-slave strobe
- s_we_o  out  1  broadcast write enable
- s_adr_o  out  32  broadcast address
- s_dat_o  out  32  broadcast write data
- s_sel_o  out  4  broadcast byte selects
- s_dat_i  in  32*NUM_SLAVES  slave read data
- s_ack_i  in  NUM_SLAVES  slave acknowledge
- s_err_i  in  NUM_SLAVES  slave error

## Operation

**States and transitions**
- IDLE → BUSY when any m_cyc_i=1.
  - The winner is the first requester at or after `last+1` (mod NUM_MASTERS).
  - `owner` and `last` are registered on the transition.
- BUSY → IDLE when m_cyc_i[owner]=0.
  - There is one dead IDLE cycle before any re-grant.
- wb_rst_i forces IDLE immediately, whatever the state (including mid-transfer, and regardless of an outstanding ack).
- Reset values:
  - owner=0; last=NUM_MASTERS-1, so master 0 wins the first tie.
  - Timeout counter 0.
  - Miss/timeout error flag 0.

**Routing in BUSY (combinational from registered owner)**
- Master-side signals of `owner` drive s_adr_o, s_dat_o, s_sel_o and s_we_o.
- Slave index idx = m_adr_i[owner][31:28].
- Valid decode (idx < NUM_SLAVES):
  - s_cyc_o[idx]=1 and s_stb_o[idx]=m_stb_i[owner]; all other slaves see 0.
  - m_ack_o[owner]=s_ack_i[idx] and m_err_o[owner]=s_err_i[idx].
  - m_dat_o[owner]=s_dat_i[idx].
- Non-owners: m_ack_o=0, m_err_o=0, m_dat_o=0.
- In IDLE: all s_cyc_o and s_stb_o are 0, and all broadcast outputs are 0.

**Decode miss (idx ≥ NUM_SLAVES with stb)**
- No slave is strobed.
- A registered err flag raises m_err_o[owner] for exactly one cycle, the cycle after stb is first seen.
- The flag then clears. If stb is still asserted on the cycle after, the miss repeats.

**Timeout (only when compiled in, see Configuration)**
- The counter increments each BUSY cycle with m_stb_i[owner]=1 and no ack/err from the selected slave.
- The counter clears on ack, err, stb low, or IDLE.
- When the counter reaches TIMEOUT:
  - m_err_o[owner]=1 for one cycle.
  - s_stb_o[idx] is forced to 0 in that cycle.
  - The counter clears.
- If a slave ack and the timeout coincide in the same cycle, the ack wins: ack is passed through and no err is raised.

## Timing
- Grant latency: m_cyc_i rises in cycle 0; owner is registered at edge 1; the slave sees cyc/stb in cycle 1.
- A combinational slave ack in cycle 1 reaches the master in cycle 1.
- Ack/err/read-data path is purely combinational (zero added latency once granted).
- Decode-miss err: one cycle after the granted stb cycle.
- Timeout err: the TIMEOUT-th consecutive waiting cycle.
- Back-to-back transfers inside one `cyc` (stb toggling, cyc held) keep the grant: no re-arbitration.

## Configuration
- WB_XBAR_TIMEOUT_EN defined:
  - Timeout counter of width $clog2(TIMEOUT+1) and forced err as described.
- Undefined:
  - No counter. A non-responding slave stalls the bus indefinitely; TIMEOUT is ignored.
  - Decode-miss error remains.

## Test plan
- Reset mid-transfer: assert wb_rst_i while master 0 is granted with stb=1 → same cycle all s_cyc_o=0, s_stb_o=0, m_ack_o=0, m_err_o=0; after release, master 0 wins the first tie.
- Round-robin fairness:
  - Setup: NUM_MASTERS=2; both masters hold cyc continuously, each releasing after one acked read.
  - Required: grants alternate 0,1,0,1.
  - Required: one dead cycle between grants.
  - Required: read data 0x1234_5678 from slave 1 (adr 0x1000_0000) returns only to the owner.
- Decode routing: master 1 writes 0x20 to adr 0x4000_0004, sel=4'b0001 → only s_cyc_o[4]/s_stb_o[4] high; s_adr_o=0x4000_0004; s_dat_o=0x20; slave ack appears on m_ack_o[1] in the same cycle.
- Decode miss: with NUM_SLAVES=5, master 0 strobes adr 0x7000_0000 → no s_stb_o asserted; m_err_o[0]=1 for exactly one cycle, one cycle after stb.
- Timeout (macro defined, TIMEOUT=4): slave 2 never acks → m_err_o=1 on the 4th waiting cycle and s_stb_o[2]=0 in that cycle.
  - Repeat with ack arriving on the 4th cycle → ack passed, no err.
  - Macro undefined → no err after 100 cycles.
